// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter sharing the read port of one asynchronous-read memory
// between two requesters. A grant registers the winner's address, the next
// edge captures the memory's combinational read data, and the winner then
// sees a one-cycle ack with the data on dataOut. At most one read per 3 cycles.
module mem_read_arbiter #(
    parameter int unsigned MEM_SIZE    = 256,
    parameter int unsigned DATA_LENGTH = 32,
    localparam int unsigned AW         = $clog2(MEM_SIZE)
) (
    input  logic                   clk,
    input  logic                   rst_b,
    input  logic                   req0,
    input  logic [AW-1:0]          addr0,
    input  logic                   req1,
    input  logic [AW-1:0]          addr1,
    output logic [AW-1:0]          memAddr,
    input  logic [DATA_LENGTH-1:0] memDataIn,
    output logic [DATA_LENGTH-1:0] dataOut,
    output logic                   ack0,
    output logic                   ack1,
    output logic                   busy
);

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StDone
    } state_e;

    state_e state_q;
    logic   owner_q;       // requester being served in READ/DONE
    logic   last_grant_q;  // requester served most recently (reset to 1 so 0 wins first)
    logic   grant1;

    // Winner selection: a lone requester wins; under contention the side not served last wins.
    always_comb begin
        grant1 = req1 & (~req0 | ~last_grant_q);
    end

    // Arbitration FSM with every output registered; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q      <= StIdle;
            memAddr      <= '0;
            dataOut      <= '0;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            busy         <= 1'b0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req0 | req1) begin
                        owner_q <= grant1;
                        memAddr <= grant1 ? addr1 : addr0;
                        busy    <= 1'b1;
                        state_q <= StRead;
                    end
                end
                StRead: begin
                    // memAddr has been stable for a full cycle, so memDataIn has settled.
                    dataOut      <= memDataIn;
                    ack0         <= ~owner_q;
                    ack1         <= owner_q;
                    last_grant_q <= owner_q;
                    state_q      <= StDone;
                end
                StDone: begin
                    ack0    <= 1'b0;
                    ack1    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    ack0    <= 1'b0;
                    ack1    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Self-checking bench for mem_read_arbiter: directed scenarios followed by
// randomized requesters, all compared against a transaction-level model.
module tb_mem_read_arbiter;

    logic        clk    = 1'b0;
    logic        rst_b  = 1'b0;
    logic        req0   = 1'b0;
    logic        req1   = 1'b0;
    logic [7:0]  addr0  = 8'h00;
    logic [7:0]  addr1  = 8'h00;
    logic [7:0]  memAddr;
    logic [31:0] memDataIn;
    logic [31:0] dataOut;
    logic        ack0;
    logic        ack1;
    logic        busy;

    int checks = 0;
    int errors = 0;

    mem_read_arbiter #(
        .MEM_SIZE   (256),
        .DATA_LENGTH(32)
    ) dut (
        .clk      (clk),
        .rst_b    (rst_b),
        .req0     (req0),
        .addr0    (addr0),
        .req1     (req1),
        .addr1    (addr1),
        .memAddr  (memAddr),
        .memDataIn(memDataIn),
        .dataOut  (dataOut),
        .ack0     (ack0),
        .ack1     (ack1),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Memory contents as a pure function of the address.
    assign memDataIn = 32'hC0DE_0000 | {24'h0, memAddr};

    // Transaction-level model: a grant at edge g yields ack at g+1, frees the port at g+3.
    int          m_cyc     = 0;
    int          m_free    = 0;
    int          m_ack_cyc = -1;
    int          m_owner   = 0;
    int          m_last    = 1;
    logic [7:0]  m_addr    = 8'h00;
    logic [31:0] m_data    = 32'h0;
    logic        m_ack0    = 1'b0;
    logic        m_ack1    = 1'b0;
    logic        m_busy    = 1'b0;

    // Ack log for the alternation scenario.
    int          ack_id[$];
    int          ack_t[$];
    logic [31:0] ack_d[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_free    = m_cyc;
        m_ack_cyc = -1;
        m_last    = 1;
        m_addr    = 8'h00;
        m_data    = 32'h0;
        m_ack0    = 1'b0;
        m_ack1    = 1'b0;
        m_busy    = 1'b0;
    endtask

    task automatic model_step(input logic r0, input logic [7:0] a0,
                              input logic r1, input logic [7:0] a1);
        m_cyc++;
        m_ack0 = 1'b0;
        m_ack1 = 1'b0;
        if (m_cyc == m_ack_cyc) begin
            m_data = 32'hC0DE_0000 | {24'h0, m_addr};
            if (m_owner == 1) m_ack1 = 1'b1;
            else m_ack0 = 1'b1;
        end
        if (m_cyc >= m_free && (r0 || r1)) begin
            if (r0 && r1) m_owner = 1 - m_last;
            else m_owner = r1 ? 1 : 0;
            m_last    = m_owner;
            m_addr    = (m_owner == 1) ? a1 : a0;
            m_ack_cyc = m_cyc + 1;
            m_free    = m_cyc + 3;
        end
        m_busy = (m_cyc < m_free - 1);
    endtask

    // One clock: snapshot inputs, advance the edge, step the model, compare all outputs.
    task automatic tick();
        logic       r0, r1;
        logic [7:0] a0, a1;
        r0 = req0;
        r1 = req1;
        a0 = addr0;
        a1 = addr1;
        @(posedge clk);
        #1;
        model_step(r0, a0, r1, a1);
        check("memAddr", 32'(memAddr), 32'(m_addr));
        check("dataOut", dataOut, m_data);
        check("ack0", 32'(ack0), 32'(m_ack0));
        check("ack1", 32'(ack1), 32'(m_ack1));
        check("busy", 32'(busy), 32'(m_busy));
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_memAddr"}, 32'(memAddr), 32'h0);
        check({tag, "_dataOut"}, dataOut, 32'h0);
        check({tag, "_ack0"}, 32'(ack0), 32'h0);
        check({tag, "_ack1"}, 32'(ack1), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
    endtask

    initial begin
        // Power-on reset
        #1;
        chk_reset("rst_init");
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        model_reset();

        // Single read from requester 0
        req0  = 1'b1;
        addr0 = 8'h05;
        tick();
        check("t2_busy", 32'(busy), 32'd1);
        tick();
        check("t2_data", dataOut, 32'hC0DE_0005);
        check("t2_ack0", 32'(ack0), 32'd1);
        check("t2_ack1", 32'(ack1), 32'd0);
        req0 = 1'b0;
        tick();
        check("t2_ack0_drop", 32'(ack0), 32'd0);
        tick();

        // Asynchronous reset in the middle of a READ
        req0  = 1'b1;
        addr0 = 8'h33;
        tick();
        #2;
        rst_b = 1'b0;
        #1;
        chk_reset("t1_async");
        @(posedge clk);
        #1;
        chk_reset("t1_held");
        req0  = 1'b0;
        rst_b = 1'b1;
        model_reset();

        // Contention after reset, then continuous alternation
        req0  = 1'b1;
        addr0 = 8'h10;
        req1  = 1'b1;
        addr1 = 8'h20;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (ack0 || ack1) begin
                ack_id.push_back(ack1 ? 1 : 0);
                ack_t.push_back(m_cyc);
                ack_d.push_back(dataOut);
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        check("t4_ack_count", 32'(ack_id.size()), 32'd4);
        if (ack_id.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("t4_owner", 32'(ack_id[i]), 32'(i % 2));
                check("t4_data", ack_d[i], (i % 2 == 0) ? 32'hC0DE_0010 : 32'hC0DE_0020);
                if (i > 0) check("t4_spacing", 32'(ack_t[i] - ack_t[i-1]), 32'd3);
            end
        end
        tick();
        tick();
        tick();

        // Abort: reset during READ of requester 1, then re-request
        req1  = 1'b1;
        addr1 = 8'hFF;
        tick();
        check("t5_busy", 32'(busy), 32'd1);
        #2;
        rst_b = 1'b0;
        #1;
        chk_reset("t5_async");
        @(posedge clk);
        #1;
        check("t5_no_ack1", 32'(ack1), 32'd0);
        rst_b = 1'b1;
        model_reset();
        tick();
        tick();
        check("t5_ack1", 32'(ack1), 32'd1);
        check("t5_data", dataOut, 32'hC0DE_00FF);
        req1 = 1'b0;
        tick();
        tick();

        // Boundary addresses back to back on requester 0
        req0  = 1'b1;
        addr0 = 8'hFF;
        tick();
        tick();
        check("t6_ack_ff", 32'(ack0), 32'd1);
        check("t6_data_ff", dataOut, 32'hC0DE_00FF);
        addr0 = 8'h00;
        tick();
        tick();
        tick();
        check("t6_ack_00", 32'(ack0), 32'd1);
        check("t6_data_00", dataOut, 32'hC0DE_0000);
        req0 = 1'b0;
        tick();
        tick();

        // Randomized requesters obeying the handshake rules
        for (int n = 0; n < 600; n++) begin
            tick();
            if (m_ack0) begin
                if ($urandom_range(1, 0) == 0) req0 = 1'b0;
                else addr0 = 8'($urandom);
            end else if (!req0 && $urandom_range(2, 0) == 0) begin
                req0  = 1'b1;
                addr0 = 8'($urandom);
            end
            if (m_ack1) begin
                if ($urandom_range(1, 0) == 0) req1 = 1'b0;
                else addr1 = 8'($urandom);
            end else if (!req1 && $urandom_range(2, 0) == 0) begin
                req1  = 1'b1;
                addr1 = 8'($urandom);
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
